soc_periph_uart_tx: RTL and testbench

SOC_PERIPH_UART_TX -- requirements
Module: soc_periph_uart_tx

---
 rtl/soc_periph_uart_pkg.sv | 20 ++
 rtl/soc_periph_uart_tx_fifo.sv | 57 +++++
 rtl/soc_periph_uart_tx.sv | 145 ++++++++++++++
 tb/tb_soc_periph_uart_tx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/soc_periph_uart_pkg.sv
// Shared types and frame constants for the UART transmitter.
package soc_periph_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned BIT_IDX_W = 3;

    // Even parity is the plain XOR; odd parity inverts it.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/soc_periph_uart_tx_fifo.sv
// Synchronous byte FIFO with occupancy output; push is refused when full.
module soc_periph_uart_tx_fifo
    import soc_periph_uart_pkg::*;
#(
    parameter int unsigned Depth = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [DATA_BITS-1:0]   wdata_i,
    input  logic                   pop_i,
    output logic [DATA_BITS-1:0]   rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] level_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = PtrW + 1;

    logic [DATA_BITS-1:0] mem [Depth];
    logic [PtrW-1:0]      wr_ptr_q;
    logic [PtrW-1:0]      rd_ptr_q;
    logic [LvlW-1:0]      level_q;
    logic                 do_push;
    logic                 do_pop;

    assign full_o  = (level_q == LvlW'(Depth));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem[rd_ptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/soc_periph_uart_tx.sv
// UART transmitter: byte FIFO feeding a start/data/parity/stop serialiser.
module soc_periph_uart_tx
    import soc_periph_uart_pkg::*;
#(
    parameter int unsigned FifoDepth = 8,
    parameter int unsigned DivWidth  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [DivWidth-1:0]        div_i,
    input  logic                       parity_en_i,
    input  logic                       parity_odd_i,
    input  logic                       two_stop_i,
    input  logic [7:0]                 data_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic                       tx_o,
    output logic                       busy_o,
    output logic [$clog2(FifoDepth):0] level_o,
    output logic                       done_o
);

    uart_state_e          state_q;
    logic [DivWidth-1:0]  cnt_q;
    logic [DivWidth-1:0]  div_q;
    logic                 par_en_q;
    logic                 par_odd_q;
    logic                 two_stop_q;
    logic                 stop_second_q;
    logic [BIT_IDX_W-1:0] bit_idx_q;
    logic [7:0]           data_q;
    logic                 tx_q;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [7:0]           fifo_rdata;
    logic                 bit_end;
    logic                 frame_end;
    logic                 pop;

    soc_periph_uart_tx_fifo #(
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (valid_i),
        .wdata_i (data_i),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    assign bit_end   = (cnt_q == '0);
    assign frame_end = (state_q == ST_STOP) && bit_end && (!two_stop_q || stop_second_q);
    // Popping at frame end as well as in IDLE lets frames run back-to-back.
    assign pop       = !fifo_empty && ((state_q == ST_IDLE) || frame_end);

    assign ready_o = !fifo_full;
    assign tx_o    = tx_q;
    assign busy_o  = (state_q != ST_IDLE);
    assign done_o  = frame_end;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            div_q         <= '0;
            par_en_q      <= 1'b0;
            par_odd_q     <= 1'b0;
            two_stop_q    <= 1'b0;
            stop_second_q <= 1'b0;
            bit_idx_q     <= '0;
            data_q        <= '0;
            tx_q          <= 1'b1;
        end else if (pop) begin
            state_q       <= ST_START;
            tx_q          <= 1'b0;
            data_q        <= fifo_rdata;
            div_q         <= div_i;
            cnt_q         <= div_i;
            par_en_q      <= parity_en_i;
            par_odd_q     <= parity_odd_i;
            two_stop_q    <= two_stop_i;
            stop_second_q <= 1'b0;
            bit_idx_q     <= '0;
        end else begin
            if (!bit_end) cnt_q <= cnt_q - 1'b1;
            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                end
                ST_START: begin
                    if (bit_end) begin
                        state_q   <= ST_DATA;
                        tx_q      <= data_q[0];
                        cnt_q     <= div_q;
                        bit_idx_q <= '0;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cnt_q <= div_q;
                        if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
                            if (par_en_q) begin
                                state_q <= ST_PARITY;
                                tx_q    <= parity_bit(data_q, par_odd_q);
                            end else begin
                                state_q       <= ST_STOP;
                                tx_q          <= 1'b1;
                                stop_second_q <= 1'b0;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            tx_q      <= data_q[bit_idx_q + 3'd1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state_q       <= ST_STOP;
                        tx_q          <= 1'b1;
                        cnt_q         <= div_q;
                        stop_second_q <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (frame_end) begin
                        state_q <= ST_IDLE;
                        tx_q    <= 1'b1;
                    end else if (bit_end) begin
                        stop_second_q <= 1'b1;
                        cnt_q         <= div_q;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_periph_uart_tx.sv
// Directed bench for soc_periph_uart_tx with hand-computed frame patterns.
module tb_soc_periph_uart_tx;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [15:0] div_i = '0;
    logic        parity_en_i = 1'b0;
    logic        parity_odd_i = 1'b0;
    logic        two_stop_i = 1'b0;
    logic [7:0]  data_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        tx_o;
    logic        busy_o;
    logic [3:0]  level_o;
    logic        done_o;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    soc_periph_uart_tx #(
        .FifoDepth (8),
        .DivWidth  (16)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .div_i        (div_i),
        .parity_en_i  (parity_en_i),
        .parity_odd_i (parity_odd_i),
        .two_stop_i   (two_stop_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .level_o      (level_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // Push one byte at edge k, leave the bench at the negedge after k+1 (frame offset 0).
    task automatic send_start(input string tag, input logic [7:0] b);
        data_i  = b;
        valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        check({tag, "_tx_before_fall"}, tx_o, 1'b1);
        @(negedge clk_i);
        check({tag, "_tx_fall"}, tx_o, 1'b0);
    endtask

    // Push two bytes at edges k and k+1, leave the bench at frame offset 0.
    task automatic send2_start(input string tag, input logic [7:0] b0, input logic [7:0] b1);
        data_i  = b0;
        valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check({tag, "_tx_before_fall"}, tx_o, 1'b1);
        data_i = b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        check({tag, "_tx_fall"}, tx_o, 1'b0);
        check({tag, "_level"}, level_o, 4'd1);
    endtask

    // bits[0] is the start bit; done_o must be high only on the last cycle.
    task automatic expect_frame(input string tag, input logic [15:0] bits,
                                input int unsigned nbits, input int unsigned hold);
        logic [15:0] pat;
        pat = bits;
        for (int unsigned off = 0; off < nbits * hold; off++) begin
            if (off != 0) @(negedge clk_i);
            check({tag, "_tx"}, tx_o, pat[off / hold]);
            check({tag, "_done"}, done_o, (off == nbits * hold - 1));
        end
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk_i);
        check({tag, "_idle_tx"}, tx_o, 1'b1);
        check({tag, "_idle_busy"}, busy_o, 1'b0);
        check({tag, "_idle_done"}, done_o, 1'b0);
    endtask

    initial begin
        int unsigned e;
        logic        acc;
        logic        saw_activity;

        repeat (2) @(negedge clk_i);
        check("rst_tx", tx_o, 1'b1);
        check("rst_ready", ready_o, 1'b1);
        check("rst_busy", busy_o, 1'b0);
        check("rst_level", level_o, 4'd0);
        check("rst_done", done_o, 1'b0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // 0x55, 4 cycles per bit, 8N1
        div_i = 16'd3;
        send_start("t55", 8'h55);
        check("t55_busy", busy_o, 1'b1);
        expect_frame("t55", 16'h02AA, 10, 4);
        expect_idle("t55");
        check("t55_level", level_o, 4'd0);

        // 0xA5, 1 cycle per bit, even then odd parity
        div_i       = 16'd0;
        parity_en_i = 1'b1;
        parity_odd_i = 1'b0;
        send_start("a5e", 8'hA5);
        expect_frame("a5e", 16'h054A, 11, 1);
        expect_idle("a5e");
        parity_odd_i = 1'b1;
        send_start("a5o", 8'hA5);
        expect_frame("a5o", 16'h074A, 11, 1);
        expect_idle("a5o");
        parity_en_i  = 1'b0;
        parity_odd_i = 1'b0;

        // two stop bits, back-to-back frames with no gap
        div_i      = 16'd1;
        two_stop_i = 1'b1;
        send2_start("ts", 8'h0F, 8'hF0);
        expect_frame("ts1", 16'h061E, 11, 2);
        @(negedge clk_i);
        expect_frame("ts2", 16'h07E0, 11, 2);
        expect_idle("ts");
        two_stop_i = 1'b0;

        // divider change mid-frame applies only to the next frame
        div_i = 16'd3;
        send2_start("dv", 8'h3C, 8'hC3);
        div_i = 16'd7;
        expect_frame("dv1", 16'h0278, 10, 4);
        @(negedge clk_i);
        expect_frame("dv2", 16'h0386, 10, 8);
        expect_idle("dv");

        // FIFO fill: 9 accepted at k..k+8, 10th at k+162
        div_i = 16'd15;
        for (int i = 0; i < 10; i++) begin
            data_i  = 8'h10 + 8'(i);
            valid_i = 1'b1;
            acc     = ready_o;
            @(posedge clk_i);
            @(negedge clk_i);
            if (i < 9) check("fill_accept", acc, 1'b1);
            else       check("fill_refuse", acc, 1'b0);
        end
        check("fill_level_full", level_o, 4'd8);
        check("fill_ready_low", ready_o, 1'b0);
        e = 10;
        while (e < 400 && !ready_o) begin
            @(posedge clk_i);
            @(negedge clk_i);
            e++;
        end
        check("fill_10th_edge", e, 32'd162);
        check("fill_level_after_pop", level_o, 4'd7);
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        check("fill_level_after_push", level_o, 4'd8);
        apply_reset();

        // reset during DATA with bytes queued
        @(negedge clk_i);
        div_i   = 16'd3;
        data_i  = 8'h80;
        valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        data_i = 8'h42;
        @(posedge clk_i);
        @(negedge clk_i);
        data_i = 8'h24;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        check("rd_level_queued", level_o, 4'd2);
        repeat (4) @(negedge clk_i);
        check("rd_tx_data0", tx_o, 1'b0);
        rst_ni = 1'b0;
        #1;
        check("rd_async_tx", tx_o, 1'b1);
        check("rd_async_level", level_o, 4'd0);
        check("rd_async_busy", busy_o, 1'b0);
        check("rd_async_ready", ready_o, 1'b1);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        saw_activity = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (tx_o !== 1'b1 || busy_o !== 1'b0 || level_o !== 4'd0) saw_activity = 1'b1;
        end
        check("rd_quiet_after_release", saw_activity, 1'b0);
        send_start("rd_new", 8'h99);
        expect_frame("rd_new", 16'h0332, 10, 4);
        expect_idle("rd_new");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
